// File: rtl/stopwatch_core.sv
// stopwatch_core: Moore control FSM, tick prescaler and BCD centisecond/second/minute counters.
// Define STOPWATCH_LAP_EN to build in the LAP state and its display freeze latches.
module stopwatch_core #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 100,
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start_pause,
    input  logic       i_stop,
    input  logic       i_lap,
    output logic [1:0] cnt_ctrl,
    output logic [7:0] o_cs_bcd,
    output logic [7:0] o_sec_bcd,
    output logic [7:0] o_min_bcd,
    output logic       o_tick,
    output logic       o_overflow
);

    localparam int unsigned DIV         = CLK_HZ / TICK_HZ;
    localparam int unsigned PW          = $clog2(DIV);
    localparam logic [7:0]  MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [7:0]     cs_q, cs_d;
    logic [7:0]     sec_q, sec_d;
    logic [7:0]     min_q, min_d;
    logic           ovf_q, ovf_d;
    logic           running;
    logic           tick_c;

    // Two-digit BCD increment; callers handle the wrap point themselves.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: stop beats start/pause, which beats lap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start_pause) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (i_stop)             state_d = ST_IDLE;
                else if (i_start_pause) state_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                else if (i_lap)         state_d = ST_LAP;
`endif
            end
            ST_PAUSE: begin
                if (i_stop)             state_d = ST_IDLE;
                else if (i_start_pause) state_d = ST_COUNT;
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (i_stop)             state_d = ST_IDLE;
                else if (i_start_pause) state_d = ST_PAUSE;
                else if (i_lap)         state_d = ST_COUNT;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    assign running = (state_q == ST_COUNT) || (state_q == ST_LAP);
`else
    assign running = (state_q == ST_COUNT);
`endif

    assign tick_c   = running && (presc_q == PW'(DIV - 1));
    assign o_tick   = tick_c;
    assign cnt_ctrl = state_q;

    // Prescaler and time chain; entering or sitting in IDLE forces everything to zero.
    always_comb begin
        presc_d = presc_q;
        cs_d    = cs_q;
        sec_d   = sec_q;
        min_d   = min_q;
        ovf_d   = ovf_q;
        if (state_d == ST_IDLE) begin
            presc_d = '0;
            cs_d    = '0;
            sec_d   = '0;
            min_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (running) begin
                presc_d = tick_c ? '0 : presc_q + PW'(1);
            end
            if (tick_c) begin
                if (cs_q != 8'h99) begin
                    cs_d = bcd_inc(cs_q);
                end else begin
                    cs_d = '0;
                    if (sec_q != 8'h59) begin
                        sec_d = bcd_inc(sec_q);
                    end else begin
                        sec_d = '0;
                        if (min_q != MAX_MIN_BCD) begin
                            min_d = bcd_inc(min_q);
                        end else begin
                            min_d = '0;
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            cs_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cs_q    <= cs_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_overflow = ovf_q;

`ifdef STOPWATCH_LAP_EN
    logic [7:0] lap_cs_q, lap_sec_q, lap_min_q;
    logic       lap_enter;
    logic       lap_show;

    assign lap_enter = (state_q != ST_LAP) && (state_d == ST_LAP);
    assign lap_show  = (state_q == ST_LAP);

    // Latches grab the pre-edge live time on LAP entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_cs_q  <= '0;
            lap_sec_q <= '0;
            lap_min_q <= '0;
        end else if (state_d == ST_IDLE) begin
            lap_cs_q  <= '0;
            lap_sec_q <= '0;
            lap_min_q <= '0;
        end else if (lap_enter) begin
            lap_cs_q  <= cs_q;
            lap_sec_q <= sec_q;
            lap_min_q <= min_q;
        end
    end

    assign o_cs_bcd  = lap_show ? lap_cs_q  : cs_q;
    assign o_sec_bcd = lap_show ? lap_sec_q : sec_q;
    assign o_min_bcd = lap_show ? lap_min_q : min_q;
`else
    logic unused_lap;
    assign unused_lap = i_lap;

    assign o_cs_bcd  = cs_q;
    assign o_sec_bcd = sec_q;
    assign o_min_bcd = min_q;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: two instances (MAX_MIN 59 and 0) share stimulus and are
// compared every cycle against a total-centiseconds reference model.
module tb_stopwatch_core;

    localparam int DIV = 10;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start_pause = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_lap = 1'b0;

    logic [1:0] a_ctrl, b_ctrl;
    logic [7:0] a_cs, a_sec, a_min, b_cs, b_sec, b_min;
    logic       a_tick, a_ovf, b_tick, b_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 count, 2 pause, 3 lap; time kept as total centiseconds.
    int m_mode;
    int m_ph;
    int m_t[2];
    int m_lap[2];
    bit m_ovf[2];
    bit m_tick_last;

    always #5 clk = ~clk;

    stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_MIN(59)) dut_a (
        .clk(clk), .rst(rst), .i_start_pause(i_start_pause), .i_stop(i_stop), .i_lap(i_lap),
        .cnt_ctrl(a_ctrl), .o_cs_bcd(a_cs), .o_sec_bcd(a_sec), .o_min_bcd(a_min),
        .o_tick(a_tick), .o_overflow(a_ovf)
    );

    stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_MIN(0)) dut_b (
        .clk(clk), .rst(rst), .i_start_pause(i_start_pause), .i_stop(i_stop), .i_lap(i_lap),
        .cnt_ctrl(b_ctrl), .o_cs_bcd(b_cs), .o_sec_bcd(b_sec), .o_min_bcd(b_min),
        .o_tick(b_tick), .o_overflow(b_ovf)
    );

    function automatic int lim(input int k);
        return (k == 0) ? 60 * 6000 : 1 * 6000;
    endfunction

    function automatic int disp(input int k);
        return (m_mode == 3) ? m_lap[k] : m_t[k];
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_ph = 0;
        m_tick_last = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0;
            m_lap[k] = 0;
            m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit s, input bit st, input bit l);
        int nm;
        bit run;
        bit tk;
        int old_t[2];
        run = (m_mode == 1) || (m_mode == 3);
        tk  = run && (m_ph == DIV - 1);
        nm  = m_mode;
        case (m_mode)
            0: if (s) nm = 1;
            1: if (st) nm = 0; else if (s) nm = 2; else if (l && LAP_EN) nm = 3;
            2: if (st) nm = 0; else if (s) nm = 1;
            3: if (st) nm = 0; else if (s) nm = 2; else if (l) nm = 1;
            default: nm = 0;
        endcase
        for (int k = 0; k < 2; k++) begin
            old_t[k] = m_t[k];
            if (tk) begin
                m_t[k] = m_t[k] + 1;
                if (m_t[k] == lim(k)) begin
                    m_t[k] = 0;
                    m_ovf[k] = 1'b1;
                end
            end
        end
        if (run) m_ph = tk ? 0 : m_ph + 1;
        if (nm == 3 && m_mode != 3) begin
            for (int k = 0; k < 2; k++) m_lap[k] = old_t[k];
        end
        if (nm == 0) begin
            m_ph = 0;
            for (int k = 0; k < 2; k++) begin
                m_t[k] = 0;
                m_lap[k] = 0;
                m_ovf[k] = 1'b0;
            end
        end
        m_mode = nm;
        m_tick_last = tk;
    endtask

    task automatic check_outputs();
        bit tk;
        tk = ((m_mode == 1) || (m_mode == 3)) && (m_ph == DIV - 1);
        chk("a_ctrl", 8'(a_ctrl), 8'(m_mode));
        chk("a_cs",   a_cs,  to_bcd(disp(0) % 100));
        chk("a_sec",  a_sec, to_bcd((disp(0) / 100) % 60));
        chk("a_min",  a_min, to_bcd(disp(0) / 6000));
        chk("a_tick", 8'(a_tick), 8'(tk));
        chk("a_ovf",  8'(a_ovf),  8'(m_ovf[0]));
        chk("b_ctrl", 8'(b_ctrl), 8'(m_mode));
        chk("b_cs",   b_cs,  to_bcd(disp(1) % 100));
        chk("b_sec",  b_sec, to_bcd((disp(1) / 100) % 60));
        chk("b_min",  b_min, to_bcd(disp(1) / 6000));
        chk("b_tick", 8'(b_tick), 8'(tk));
        chk("b_ovf",  8'(b_ovf),  8'(m_ovf[1]));
    endtask

    task automatic step(input bit s, input bit st, input bit l);
        i_start_pause = s;
        i_stop = st;
        i_lap = l;
        @(posedge clk);
        model_edge(s, st, l);
        #1;
        i_start_pause = 1'b0;
        i_stop = 1'b0;
        i_lap = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_ticks(input int n);
        int got;
        int budget;
        got = 0;
        budget = n * DIV + 2 * DIV;
        while (got < n && budget > 0) begin
            step(1'b0, 1'b0, 1'b0);
            if (m_tick_last) got++;
            budget--;
        end
        checks++;
        assert (got == n) else begin
            errors++;
            $error("FAIL run_ticks: observed %0d ticks expected %0d", got, n);
        end
    endtask

    task automatic chk_a_disp(input string tag, input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] cs);
        chk({tag, "_min"}, a_min, mn);
        chk({tag, "_sec"}, a_sec, sc);
        chk({tag, "_cs"},  a_cs,  cs);
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_ctrl", 8'(a_ctrl), 8'h00);
        chk_a_disp("rst", 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Start, first tick, 100 ticks -> 00:01.00
        step(1'b1, 1'b0, 1'b0);
        chk("t1_ctrl", 8'(a_ctrl), 8'h01);
        idle(8);
        chk("t1_tick_early", 8'(a_tick), 8'h00);
        idle(1);
        chk("t1_tick_first", 8'(a_tick), 8'h01);
        run_ticks(100);
        chk_a_disp("t1", 8'h00, 8'h01, 8'h00);

        // Pause keeps partial tick
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_ticks(25);
        idle(4);
        step(1'b1, 1'b0, 1'b0);
        chk("t2_ctrl_pause", 8'(a_ctrl), 8'h02);
        idle(50);
        chk_a_disp("t2_hold", 8'h00, 8'h00, 8'h25);
        step(1'b1, 1'b0, 1'b0);
        idle(10);
        chk_a_disp("t2_resume", 8'h00, 8'h00, 8'h26);

        // Stop wins over start/pause in the same cycle
        step(1'b1, 1'b0, 1'b0);
        idle(23);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_ctrl", 8'(a_ctrl), 8'h00);
        chk_a_disp("t3", 8'h00, 8'h00, 8'h00);

        // Async reset mid-count at 00:02.40, then stop in IDLE
        step(1'b1, 1'b0, 1'b0);
        run_ticks(240);
        chk_a_disp("t6_pre", 8'h00, 8'h02, 8'h40);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("t6_ctrl", 8'(a_ctrl), 8'h00);
        chk_a_disp("t6_rst", 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        chk("t6_idle_ctrl", 8'(a_ctrl), 8'h00);
        chk_a_disp("t6_idle", 8'h00, 8'h00, 8'h00);

        // Lap freeze and release
        step(1'b1, 1'b0, 1'b0);
        run_ticks(317);
        step(1'b0, 1'b0, 1'b1);
        if (LAP_EN) begin
            chk("t5_ctrl_lap", 8'(a_ctrl), 8'h03);
            chk_a_disp("t5_latch", 8'h00, 8'h03, 8'h17);
            run_ticks(200);
            chk_a_disp("t5_frozen", 8'h00, 8'h03, 8'h17);
            step(1'b0, 1'b0, 1'b1);
            chk("t5_ctrl_back", 8'(a_ctrl), 8'h01);
            chk_a_disp("t5_live", 8'h00, 8'h05, 8'h17);
        end else begin
            chk("t5_ctrl_nolap", 8'(a_ctrl), 8'h01);
            run_ticks(200);
            chk_a_disp("t5_live", 8'h00, 8'h05, 8'h17);
        end
        step(1'b0, 1'b1, 1'b0);

        // Randomized pulse traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0);
        end
        step(1'b0, 1'b1, 1'b0);

        // Wrap at MAX_MIN:59.99 on the MAX_MIN=0 instance, minute carry on the other
        step(1'b1, 1'b0, 1'b0);
        run_ticks(5999);
        chk("t4_b_min", b_min, 8'h00);
        chk("t4_b_sec", b_sec, 8'h59);
        chk("t4_b_cs",  b_cs,  8'h99);
        chk("t4_b_ovf_pre", 8'(b_ovf), 8'h00);
        run_ticks(1);
        chk("t4_b_wrap_sec", b_sec, 8'h00);
        chk("t4_b_wrap_cs",  b_cs,  8'h00);
        chk("t4_b_ovf", 8'(b_ovf), 8'h01);
        chk_a_disp("t4_a", 8'h01, 8'h00, 8'h00);
        chk("t4_a_ovf", 8'(a_ovf), 8'h00);
        idle(30);
        chk("t4_b_ovf_sticky", 8'(b_ovf), 8'h01);
        step(1'b0, 1'b1, 1'b0);
        chk("t4_b_ovf_clr", 8'(b_ovf), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
